memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage.sv | 134 +++++++++++++
 tb/tb_memory_access_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// EX/MEM memory access stage: passes ALU results through in one cycle, or runs a
// single load/store handshake on the memory bus with an ack timeout.
module memory_access_stage #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [3:0]  OP_LOAD  = 4'b0010,
  parameter logic [3:0]  OP_STORE = 4'b0011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic [19:0] aluRESULT,
  input  logic [19:0] store_data,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [19:0] mem_addr,
  output logic [19:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [19:0] mem_rdata,
  output logic        valid_out,
  output logic [19:0] aluRESULTout,
  output logic [19:0] memory_read_data,
  output logic        mem_error
);

  localparam int unsigned DW = 20;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   ack_count, ack_count_n;
  logic            mem_req_n, mem_we_n, valid_out_n, mem_error_n;
  logic [DW-1:0]   mem_addr_n, mem_wdata_n, alu_out_n, rdata_n;
  logic            is_mem, is_store;

  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      ack_count        <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      valid_out        <= 1'b0;
      aluRESULTout     <= '0;
      memory_read_data <= '0;
      mem_error        <= 1'b0;
    end else begin
      state            <= state_n;
      ack_count        <= ack_count_n;
      mem_req          <= mem_req_n;
      mem_we           <= mem_we_n;
      mem_addr         <= mem_addr_n;
      mem_wdata        <= mem_wdata_n;
      valid_out        <= valid_out_n;
      aluRESULTout     <= alu_out_n;
      memory_read_data <= rdata_n;
      mem_error        <= mem_error_n;
    end
  end

  // Next state, next outputs, and the combinational stall
  always_comb begin
    state_n     = state;
    ack_count_n = ack_count;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    alu_out_n   = aluRESULTout;
    rdata_n     = memory_read_data;
    valid_out_n = 1'b0;
    mem_error_n = 1'b0;
    stall       = 1'b0;

    case (state)
      IDLE: begin
        if (valid_in) begin
          if (is_mem) begin
            stall       = 1'b1;
            state_n     = ACCESS;
            mem_req_n   = 1'b1;
            mem_we_n    = is_store;
            mem_addr_n  = aluRESULT;
            mem_wdata_n = is_store ? store_data : '0;
            ack_count_n = '0;
          end else begin
            valid_out_n = 1'b1;
            alu_out_n   = aluRESULT;
            rdata_n     = '0;
          end
        end
      end

      ACCESS: begin
        stall = 1'b1;
        // An ack on the final allowed cycle beats the timeout
        if (mem_ack) begin
          state_n     = DONE;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          rdata_n     = mem_we ? '0 : mem_rdata;
          alu_out_n   = mem_addr;
          valid_out_n = 1'b1;
        end else if (ack_count == CW'(TIMEOUT - 1)) begin
          state_n     = DONE;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          rdata_n     = '0;
          alu_out_n   = mem_addr;
          valid_out_n = 1'b1;
          mem_error_n = 1'b1;
        end else begin
          ack_count_n = ack_count + CW'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboarded bench for memory_access_stage: pass-through, load, store,
// timeout, last-cycle ack, DONE-cycle blocking and mid-access reset.
module tb_memory_access_stage;

  localparam logic [3:0] LOAD  = 4'b0010;
  localparam logic [3:0] STORE = 4'b0011;
  localparam int         TMO   = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [3:0]  opcode = '0;
  logic [19:0] aluRESULT = '0;
  logic [19:0] store_data = '0;
  logic        stall;
  logic        mem_req, mem_we;
  logic [19:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [19:0] mem_rdata = '0;
  logic        valid_out;
  logic [19:0] aluRESULTout, memory_read_data;
  logic        mem_error;

  typedef struct packed {
    logic [19:0] alu;
    logic [19:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;

  memory_access_stage #(.TIMEOUT(TMO), .OP_LOAD(LOAD), .OP_STORE(STORE)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .opcode(opcode),
    .aluRESULT(aluRESULT), .store_data(store_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .valid_out(valid_out),
    .aluRESULTout(aluRESULTout), .memory_read_data(memory_read_data),
    .mem_error(mem_error)
  );

  always #5 clock = ~clock;

  // Result monitor: every valid_out must match the oldest expected result
  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      if (valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          $display("FAIL unexpected_valid_out: got alu=%h rd=%h err=%b, none expected",
                   aluRESULTout, memory_read_data, mem_error);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({aluRESULTout, memory_read_data, mem_error} !== e)
            $display("FAIL result: got alu=%h rd=%h err=%b, want alu=%h rd=%h err=%b",
                     aluRESULTout, memory_read_data, mem_error, e.alu, e.rd, e.err);
          else n_pass++;
        end
      end else begin
        if (mem_error !== 1'b0) $display("FAIL error_without_valid: mem_error=%b want 0", mem_error);
        else n_pass++;
      end
    end
  end

  // Runs one memory op; ack_at = ACCESS cycle carrying the ack (0 = never)
  task automatic do_mem(input logic [3:0] op, input logic [19:0] addr, input logic [19:0] wd,
                        input logic [19:0] rd, input int ack_at,
                        output int reqc, output int stc, output logic bus_ok);
    logic err, is_st, done;
    err   = (ack_at < 1) || (ack_at > TMO);
    is_st = (op == STORE);
    valid_in = 1'b1; opcode = op; aluRESULT = addr; store_data = wd;
    mem_rdata = rd; mem_ack = 1'b0;
    sb.push_back({addr, (is_st || err) ? 20'h0 : rd, err});
    reqc = 0; stc = 0; bus_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (stall === 1'b1) stc++;
      if (mem_req === 1'b1) begin
        reqc++;
        if (mem_addr !== addr || mem_we !== is_st || mem_wdata !== (is_st ? wd : 20'h0))
          bus_ok = 1'b0;
        mem_ack = (reqc == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (c > 0 && stall !== 1'b1) done = 1'b1;
      else @(negedge clock);
    end
    valid_in = 1'b0; opcode = '0; mem_ack = 1'b0;
    n_checks++;
    if (!done) $display("FAIL op_complete: stall still %b after 40 cycles, want 0", stall);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock); #1;
    n_checks++;
    if ({mem_req, mem_we, valid_out, mem_error, stall} !== 5'b0)
      $display("FAIL reset_ctrl: req/we/vo/err/stall=%b want 00000",
               {mem_req, mem_we, valid_out, mem_error, stall});
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, aluRESULTout, memory_read_data} !== 80'h0)
      $display("FAIL reset_data: addr=%h wdata=%h alu=%h rd=%h want all 0",
               mem_addr, mem_wdata, aluRESULTout, memory_read_data);
    else n_pass++;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_non_mem();
    int st;
    st = 0;
    valid_in = 1'b1; opcode = 4'b0000; aluRESULT = 20'h00ABC;
    sb.push_back({20'h00ABC, 20'h0, 1'b0});
    #1; if (stall === 1'b1) st++;
    @(negedge clock); #1;
    valid_in = 1'b0;
    if (stall === 1'b1) st++;
    n_checks++;
    if (valid_out !== 1'b1 || aluRESULTout !== 20'h00ABC)
      $display("FAIL non_mem: vo=%b alu=%h want 1 00abc", valid_out, aluRESULTout);
    else n_pass++;
    n_checks++;
    if (st != 0) $display("FAIL non_mem_stall: stall cycles=%0d want 0", st);
    else n_pass++;
    @(negedge clock);
  endtask

  task automatic test_load();
    int reqc, stc; logic ok;
    do_mem(LOAD, 20'h00010, 20'h0, 20'hFACE5, 3, reqc, stc, ok);
    n_checks++;
    if (reqc != 3 || stc != 4) $display("FAIL load_cycles: req=%0d stall=%0d want 3 4", reqc, stc);
    else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL load_bus: request bus unstable or wrong, want addr 00010 we 0");
    else n_pass++;
  endtask

  task automatic test_store();
    int reqc, stc; logic ok;
    do_mem(STORE, 20'h00020, 20'h12345, 20'h55555, 1, reqc, stc, ok);
    n_checks++;
    if (reqc != 1 || stc != 2) $display("FAIL store_cycles: req=%0d stall=%0d want 1 2", reqc, stc);
    else n_pass++;
    n_checks++;
    if (!ok) $display("FAIL store_bus: want addr 00020 we 1 wdata 12345 while req high");
    else n_pass++;
  endtask

  task automatic test_timeout();
    int reqc, stc; logic ok;
    do_mem(LOAD, 20'h00030, 20'h0, 20'hDEAD1, 0, reqc, stc, ok);
    n_checks++;
    if (reqc != TMO || stc != TMO + 1)
      $display("FAIL timeout_cycles: req=%0d stall=%0d want %0d %0d", reqc, stc, TMO, TMO + 1);
    else n_pass++;
  endtask

  task automatic test_ack_last();
    int reqc, stc; logic ok;
    do_mem(LOAD, 20'h00040, 20'h0, 20'h0BEEF, TMO, reqc, stc, ok);
    n_checks++;
    if (reqc != TMO || !ok) $display("FAIL ack_last: req=%0d bus_ok=%b want %0d 1", reqc, ok, TMO);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    valid_in = 1'b1; opcode = 4'b0000; aluRESULT = 20'h00111;
    sb.push_back({20'h00111, 20'h0, 1'b0});
    @(negedge clock);
    opcode = 4'b0101; aluRESULT = 20'h00222;
    sb.push_back({20'h00222, 20'h0, 1'b0});
    @(negedge clock);
    valid_in = 1'b0;
    mem_ack = 1'b1;
    @(negedge clock); #1;
    mem_ack = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0 || valid_out !== 1'b0)
      $display("FAIL idle_ack: req=%b vo=%b want 0 0", mem_req, valid_out);
    else n_pass++;
    valid_in = 1'b1; opcode = LOAD; aluRESULT = 20'h00070; mem_rdata = 20'h13579;
    sb.push_back({20'h00070, 20'h13579, 1'b0});
    @(negedge clock); #1;
    mem_ack = 1'b1;
    @(negedge clock); #1;
    mem_ack = 1'b0;
    n_checks++;
    if (stall !== 1'b0 || valid_out !== 1'b1)
      $display("FAIL done_cycle: stall=%b vo=%b want 0 1", stall, valid_out);
    else n_pass++;
    opcode = 4'b0000; aluRESULT = 20'h00888;
    @(negedge clock); #1;
    n_checks++;
    if (valid_out !== 1'b0) $display("FAIL done_blocks: vo=%b want 0", valid_out);
    else n_pass++;
    sb.push_back({20'h00888, 20'h0, 1'b0});
    @(negedge clock); #1;
    valid_in = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_access();
    int reqc, stc; logic ok;
    valid_in = 1'b1; opcode = LOAD; aluRESULT = 20'h00050;
    @(negedge clock);
    @(negedge clock); #1;
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL mid_req: req=%b want 1", mem_req);
    else n_pass++;
    reset = 1'b1; valid_in = 1'b0;
    @(negedge clock); #1;
    n_checks++;
    if ({mem_req, mem_we, valid_out, mem_error, stall} !== 5'b0 ||
        {mem_addr, mem_wdata, aluRESULTout, memory_read_data} !== 80'h0)
      $display("FAIL mid_reset: req=%b vo=%b addr=%h alu=%h rd=%h want all 0",
               mem_req, valid_out, mem_addr, aluRESULTout, memory_read_data);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    do_mem(LOAD, 20'h00060, 20'h0, 20'h0ABCD, 2, reqc, stc, ok);
    n_checks++;
    if (reqc != 2 || stc != 3 || !ok)
      $display("FAIL post_reset_load: req=%0d stall=%0d ok=%b want 2 3 1", reqc, stc, ok);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_load();
    test_store();
    test_timeout();
    test_ack_last();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d results pending want 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
